seg_scroll_ctrl: RTL and testbench
==================================

Name: seg_scroll_ctrl

Overview:
Scan and scroll controller for the 8-digit seven-segment board.
- Holds a message buffer of up to 16 characters, written by a host port.
- Time-multiplexes the 8 digits at a prescaled scan rate.
- Optionally scrolls the message one character left every SCROLL_FRAMES full frames.
- Drives active-high cathodes/anodes. Board-polarity inversion stays in the top-level wrapper.

Parameters:
- MSG_LEN, 16: message length in characters. Legal range 8..16.
- SCAN_DIV, 1000: clk cycles per digit slot. Minimum 2.
- SCROLL_FRAMES, 250: full 8-digit frames per scroll step. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  write strobe for the message buffer
- wr_addr  in  4  character index to write
- wr_data  in  5  character code: bit4 = blank, bits3:0 = hex glyph
- scroll_en  in  1  1 = advance the offset on schedule; 0 = freeze the offset
- restart  in  1  synchronous pulse: return to offset 0, digit 0
- cathodes  out  8  segments {a,b,c,d,e,f,g,dp}, a = MSB, dp always 0
- anodes  out  8  one-hot digit select; digit 0 = MSB (leftmost)
- wrap  out  1  one-cycle pulse when the offset wraps MSG_LEN-1 -> 0

Behaviour:
- Reset (asynchronous, rst=1):
  - cathodes=0, anodes=0, wrap=0.
  - Prescaler=0, pos=0, offset=0, frame_cnt=0.
  - Message buffer is NOT cleared. Its contents are undefined until written.
- Writes:
  - Accepted when wr_en=1 and wr_addr<MSG_LEN. Writes with wr_addr>=MSG_LEN are ignored.
  - A write is visible to the scan from the next clock edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 in the cycle where the count equals SCAN_DIV-1.
- On tick, the outputs register the current pos, then pos advances:
  - anodes <= 8'b1000_0000 >> pos
  - cathodes <= {glyph(buf[(offset+pos) mod MSG_LEN]), 1'b0}
  - pos <= pos+1 (mod 8)
  - Outputs therefore change one cycle after tick and hold for SCAN_DIV cycles.
- Glyph table (7-bit, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Blank code (bit4=1) = 0000000.
- Frame end is a tick with pos==7. On frame end:
  - If scroll_en=1: when frame_cnt==SCROLL_FRAMES-1, then frame_cnt<=0 and offset<=offset+1 mod MSG_LEN; otherwise frame_cnt<=frame_cnt+1.
  - If scroll_en=0: offset and frame_cnt hold.
  - The new offset first applies to digit 0 of the next frame. No mid-frame tearing.
- wrap: asserted in the cycle after the offset update from MSG_LEN-1 to 0.
- restart=1:
  - Prescaler, pos, offset and frame_cnt go to 0.
  - anodes and cathodes go to 0; wrap goes to 0.
  - restart has priority over tick and over frame-end actions in the same cycle.
- Simultaneous write and scan of the same character: the scan uses the old value in that cycle.
- scroll_en deasserted mid-frame: the current frame completes without a step.
- Asynchronous reset mid-slot: outputs blank immediately. The first tick after release shows digit 0 at offset 0.

Optional Feature:
- Macro: SEG_DIM_EN.
- When defined:
  - Adds input port duty [2:0].
  - Within each slot, anodes are forced to 0 while prescaler >= ((duty+1)*SCAN_DIV)>>3. duty=7 gives full brightness.
  - cathodes are unaffected.
  - SCAN_DIV must be a multiple of 8; a violation is a compile-time error.
- When not defined: no duty port; anodes are driven for the whole slot.

Test Plan:
All scenarios use SCAN_DIV=4, SCROLL_FRAMES=2, MSG_LEN=10.
1. Reset, write buf[0..9]=0..9, scroll_en=0:
   - First tick at cycle 3 -> cycle 4: anodes=8'h80, cathodes=8'hFC.
   - Next slot: anodes=8'h40, cathodes=8'h60.
   - After 8 slots, the sequence repeats from digit 0.
2. scroll_en=1:
   - After 2 frames (64 clk), digit 0 shows char 1 (cathodes=8'h60).
   - After 20 frames, offset returns to 0, wrap pulses exactly once for 1 cycle, and digit 7 shows char 7 (8'hE0).
3. Offset=5, digit 6 -> buf[(5+6) mod 10]=buf[1] displayed. Wrap-around indexing checked.
4. restart asserted in the same cycle as tick at pos=7:
   - anodes=0, offset=0, frame_cnt unchanged by the frame end.
   - The next slot shows anodes=8'h80.
5. Write wr_addr=12 with wr_data=5'h08 -> buffer unchanged. Write buf[3]=5'h10 -> digit 3 blank (cathodes=8'h00).
6. SEG_DIM_EN, SCAN_DIV=8, duty=1 -> anodes active for 2 of 8 cycles per slot. duty=7 -> 8 of 8.

Source files
------------

// File: rtl/seg_scroll_ctrl.sv
// Scan and scroll controller for an 8-digit seven-segment display with a 16-entry message buffer.
// Optional anode dimming is compiled in when SEG_DIM_EN is defined.
module seg_scroll_ctrl #(
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 1000,
    parameter int SCROLL_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SEG_DIM_EN
    input  logic [2:0] duty,
`endif
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       scroll_en,
    input  logic       restart,
    output logic [7:0] cathodes,
    output logic [7:0] anodes,
    output logic       wrap
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [4:0]    msg_buf [16];
    logic [PW-1:0] pre;
    logic [2:0]    pos;
    logic [3:0]    offset;
    logic [FW-1:0] frame_cnt;
    logic [7:0]    anodes_r;
    logic          tick;
    logic          frame_end;
    logic          step;
    logic          last_off;
    logic [4:0]    sum;
    logic [4:0]    idx;
    logic [4:0]    cur_char;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c[3:0])
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return c[4] ? 7'b0 : g;
    endfunction

    // Buffer is deliberately not reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < MSG_LEN))
            msg_buf[wr_addr] <= wr_data;
    end

    assign tick      = (pre == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (pos == 3'd7);
    assign step      = frame_end && scroll_en && (frame_cnt == FW'(SCROLL_FRAMES - 1));
    assign last_off  = (offset == 4'(MSG_LEN - 1));

    // offset < MSG_LEN and pos < 8 <= MSG_LEN, so one subtraction is a full modulo.
    assign sum      = {1'b0, offset} + {2'b00, pos};
    assign idx      = (sum >= 5'(MSG_LEN)) ? sum - 5'(MSG_LEN) : sum;
    assign cur_char = msg_buf[idx[3:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            pos       <= '0;
            offset    <= '0;
            frame_cnt <= '0;
            anodes_r  <= '0;
            cathodes  <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (restart) begin
                pre       <= '0;
                pos       <= '0;
                offset    <= '0;
                frame_cnt <= '0;
                anodes_r  <= '0;
                cathodes  <= '0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    anodes_r <= 8'h80 >> pos;
                    cathodes <= {glyph(cur_char), 1'b0};
                    pos      <= pos + 3'd1;
                end
                // Offset only moves at frame end, so a frame never mixes two offsets.
                if (frame_end && scroll_en) begin
                    if (step) begin
                        frame_cnt <= '0;
                        offset    <= last_off ? 4'd0 : offset + 4'd1;
                        wrap      <= last_off;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SEG_DIM_EN
    if (SCAN_DIV % 8 != 0) begin : g_div_chk
        $error("SCAN_DIV must be a multiple of 8 when dimming is enabled");
    end

    // Slot starts with pre=0, so anodes light for the first (duty+1)/8 of it.
    logic [31:0] dim_thr;
    assign dim_thr = ((32'(duty) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    assign anodes  = (32'(pre) < dim_thr) ? anodes_r : 8'h00;
`else
    assign anodes = anodes_r;
`endif

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed self-checking bench for seg_scroll_ctrl (MSG_LEN=10, SCROLL_FRAMES=2).
module tb_seg_scroll_ctrl;
`ifdef SEG_DIM_EN
    localparam int SD = 8;
`else
    localparam int SD = 4;
`endif
    localparam int ML = 10;
    localparam int SF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic       scroll_en = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] cathodes;
    logic [7:0] anodes;
    logic       wrap;
`ifdef SEG_DIM_EN
    logic [2:0] duty = 3'd7;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scroll_ctrl #(.MSG_LEN(ML), .SCAN_DIV(SD), .SCROLL_FRAMES(SF)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SEG_DIM_EN
        .duty     (duty),
`endif
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .scroll_en(scroll_en),
        .restart  (restart),
        .cathodes (cathodes),
        .anodes   (anodes),
        .wrap     (wrap)
    );

    function automatic logic [7:0] seg(input logic [4:0] c);
        logic [7:0] s;
        case (c[3:0])
            4'h0: s = 8'hFC; 4'h1: s = 8'h60; 4'h2: s = 8'hDA; 4'h3: s = 8'hF2;
            4'h4: s = 8'h66; 4'h5: s = 8'hB6; 4'h6: s = 8'hBE; 4'h7: s = 8'hE0;
            4'h8: s = 8'hFE; 4'h9: s = 8'hF6; 4'hA: s = 8'hEE; 4'hB: s = 8'h3E;
            4'hC: s = 8'h9C; 4'hD: s = 8'h7A; 4'hE: s = 8'h9E; default: s = 8'h8E;
        endcase
        return c[4] ? 8'h00 : s;
    endfunction

    // Cycle (counted from the first cycle after restart) where frame f, digit d first shows.
    function automatic int at(input int f, input int d);
        return SD * (1 + 8 * f + d);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    logic [7:0] exp5 [8] = '{8'hFC, 8'h60, 8'hDA, 8'h00, 8'h66, 8'hB6, 8'hBE, 8'hE0};
    int wraps;
    int lit;

    initial begin
        #1;
        chk("rst_anodes", anodes, 8'h00);
        chk("rst_cathodes", cathodes, 8'h00);
        chk("rst_wrap", {7'b0, wrap}, 8'h00);
        step(2);
        rst = 1'b0;

        // 1: static scan of 0..9, restart held while loading
        restart = 1'b1;
        for (int i = 0; i < ML; i++) wr(4'(i), 5'(i));
        restart = 1'b0;
        chk("restart_held_anodes", anodes, 8'h00);
        step(SD - 1);
        chk("first_tick_early", anodes, 8'h00);
        step(1);
        chk("d0_anodes", anodes, 8'h80);
        chk("d0_cathodes", cathodes, 8'hFC);
        for (int d = 1; d < 8; d++) begin
            step(SD);
            chk("scan_anodes", anodes, 8'h80 >> d);
            chk("scan_cathodes", cathodes, seg(5'(d)));
        end
        step(SD);
        chk("repeat_anodes", anodes, 8'h80);
        chk("repeat_cathodes", cathodes, 8'hFC);

        // 2/3: scrolling, wrap-around indexing, single wrap pulse
        scroll_en = 1'b1;
        do_restart();
        wraps = 0;
        for (int c = 1; c <= at(21, 0); c++) begin
            step(1);
            if (wrap) wraps++;
            if (c == at(1, 0)) chk("f1_d0_no_step", cathodes, 8'hFC);
            if (c == at(1, 7)) chk("f1_d7_no_tear", cathodes, 8'hE0);
            if (c == at(2, 0)) chk("f2_d0_step", cathodes, 8'h60);
            if (c == at(10, 0)) chk("off5_d0", cathodes, 8'hB6);
            if (c == at(10, 6)) chk("off5_d6_wrapidx", cathodes, 8'h60);
            if (c == 160 * SD - 1) chk("wrap_before", {7'b0, wrap}, 8'h00);
            if (c == 160 * SD) chk("wrap_pulse", {7'b0, wrap}, 8'h01);
            if (c == 160 * SD + 1) chk("wrap_after", {7'b0, wrap}, 8'h00);
            if (c == at(20, 0)) chk("f20_d0", cathodes, 8'hFC);
            if (c == at(20, 7)) chk("f20_d7", cathodes, 8'hE0);
        end
        chk("wrap_count", 8'(wraps), 8'h01);

        // 4: restart on the frame-end tick that would step the offset
        do_restart();
        step(16 * SD - 1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("rs_anodes", anodes, 8'h00);
        chk("rs_cathodes", cathodes, 8'h00);
        step(SD);
        chk("rs_next_anodes", anodes, 8'h80);
        chk("rs_next_cathodes", cathodes, 8'hFC);
        step(8 * SD);
        chk("rs_f1_d0", cathodes, 8'hFC);
        step(8 * SD);
        chk("rs_f2_d0", cathodes, 8'h60);

        // 5: ignored write, blank char, write colliding with its own scan
        scroll_en = 1'b0;
        do_restart();
        wr(4'd12, 5'h08);
        wr(4'd3, 5'h10);
        step(SD - 3);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'h0A;
        step(1);
        wr_en = 1'b0;
        chk("coll_old_value", cathodes, 8'hFC);
        for (int d = 1; d < 8; d++) begin
            step(SD);
            chk("wr_scan", cathodes, exp5[d]);
        end
        step(SD);
        chk("coll_new_value", cathodes, 8'hEE);

        // async reset mid-slot with offset and frame_cnt both nonzero
        scroll_en = 1'b1;
        do_restart();
        step(25 * SD);
        chk("pre_rst_anodes", anodes, 8'h80);
        #2 rst = 1'b1;
        #1;
        chk("async_anodes", anodes, 8'h00);
        chk("async_cathodes", cathodes, 8'h00);
        rst = 1'b0;
        step(SD);
        chk("post_rst_anodes", anodes, 8'h80);
        chk("post_rst_cathodes", cathodes, 8'hEE);
        step(8 * SD);
        chk("post_rst_f1", cathodes, 8'hEE);
        step(8 * SD);
        chk("post_rst_f2", cathodes, 8'h60);

`ifdef SEG_DIM_EN
        scroll_en = 1'b0;
        duty = 3'd1;
        do_restart();
        step(SD);
        lit = 0;
        for (int i = 0; i < SD; i++) begin
            if (anodes != 8'h00) lit++;
            step(1);
        end
        chk("dim_duty1", 8'(lit), 8'd2);
        duty = 3'd7;
        lit = 0;
        for (int i = 0; i < SD; i++) begin
            if (anodes != 8'h00) lit++;
            step(1);
        end
        chk("dim_duty7", 8'(lit), 8'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
